// File: rtl/vga_onchip_ram_scan.sv
// vga_onchip_ram_scan: true dual-port framebuffer RAM.
//   Port A: Avalon-MM slave s1 (byte-lane writes, pipelined reads).
//   Port B: autonomous read-only scan-out streamed over valid/ready.
// Build option: define ONCHIP_RAM_OUTREG_EN to add an s1 output register
// (read latency 2) and a scan pipeline stage with a 3-entry skid FIFO
// (first scan word 3 cycles after start).
module vga_onchip_ram_scan #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BYTE_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DEPTH      = 33000,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clken,
  input  logic                             reset_req,
  input  logic [ADDR_WIDTH-1:0]            s1_address,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] s1_byteenable,
  input  logic                             s1_chipselect,
  input  logic                             s1_read,
  input  logic                             s1_write,
  input  logic [DATA_WIDTH-1:0]            s1_writedata,
  output logic [DATA_WIDTH-1:0]            s1_readdata,
  output logic                             s1_readdatavalid,
  output logic                             s1_waitrequest,
  input  logic                             scan_start,
  input  logic                             scan_abort,
  input  logic [ADDR_WIDTH-1:0]            scan_base,
  input  logic [LEN_WIDTH-1:0]             scan_words,
  output logic [DATA_WIDTH-1:0]            scan_data,
  output logic                             scan_valid,
  input  logic                             scan_ready,
  output logic                             scan_sop,
  output logic                             scan_eop,
  output logic                             scan_busy
);

  localparam int unsigned NUM_LANES  = DATA_WIDTH / BYTE_WIDTH;
`ifdef ONCHIP_RAM_OUTREG_EN
  localparam int unsigned FIFO_DEPTH = 3;
`else
  localparam int unsigned FIFO_DEPTH = 2;
`endif
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [PTR_W-1:0]      LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);

  typedef struct packed {
    logic                  sop;
    logic                  eop;
    logic [DATA_WIDTH-1:0] data;
  } scan_entry_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // ---------------------------------------------------------------- storage
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // ---------------------------------------------------------------- port A
  logic                  w_s1_accept;
  logic                  w_s1_wr;
  logic                  w_s1_rd;
  logic                  w_s1_in_range;
  logic [DATA_WIDTH-1:0] w_s1_rdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_rdv;

  assign s1_waitrequest = ~clken | reset_req | reset;
  assign w_s1_accept    = s1_chipselect & ~s1_waitrequest;
  assign w_s1_wr        = w_s1_accept & s1_write;
  assign w_s1_rd        = w_s1_accept & s1_read & ~s1_write;
  assign w_s1_in_range  = 32'(s1_address) < DEPTH;

  // Out-of-range s1 reads return zero
  always_comb begin
    w_s1_rdata = '0;
    if (w_s1_in_range) w_s1_rdata = r_mem[s1_address];
  end

  // Byte-lane merge on s1 writes; out-of-range writes are dropped
  always_ff @(posedge clk) begin
    if (w_s1_wr && w_s1_in_range) begin
      for (int i = 0; i < int'(NUM_LANES); i++) begin
        if (s1_byteenable[i])
          r_mem[s1_address][i*BYTE_WIDTH +: BYTE_WIDTH] <= s1_writedata[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

`ifdef ONCHIP_RAM_OUTREG_EN
  logic [DATA_WIDTH-1:0] r_a_data;
  logic                  r_a_valid;

  // First s1 read stage, held while the slave is clock-gated
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a_data  <= '0;
      r_a_valid <= 1'b0;
    end else if (clken) begin
      r_a_valid <= w_s1_rd;
      if (w_s1_rd) r_a_data <= w_s1_rdata;
    end
  end

  // s1 output register, frozen while clken is low
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
      r_rdv   <= 1'b0;
    end else if (clken) begin
      r_rdv <= r_a_valid;
      if (r_a_valid) r_rdata <= r_a_data;
    end
  end
`else
  // Single-stage s1 read; data holds between valid pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
      r_rdv   <= 1'b0;
    end else begin
      r_rdv <= w_s1_rd;
      if (w_s1_rd) r_rdata <= w_s1_rdata;
    end
  end
`endif

  assign s1_readdata      = r_rdata;
  assign s1_readdatavalid = r_rdv;

  // ---------------------------------------------------------------- port B
  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_remain;
  logic                  r_first;
  scan_entry_t           r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [CNT_W-1:0]      r_count;

  logic                  w_load;
  logic                  w_issue;
  logic                  w_flush;
  logic                  w_room;
  logic                  w_inflight;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_valid;
  scan_entry_t           w_head;
  scan_entry_t           w_rd_entry;
  scan_entry_t           w_push_entry;
  logic [DATA_WIDTH-1:0] w_b_rdata;

  // Port B read of the current scan address, tagged with sop/eop
  always_comb begin
    w_b_rdata = '0;
    if (32'(r_addr) < DEPTH) w_b_rdata = r_mem[r_addr];
    w_rd_entry.sop  = r_first;
    w_rd_entry.eop  = (r_remain == LEN_WIDTH'(1));
    w_rd_entry.data = w_b_rdata;
  end

  assign w_head  = r_fifo[r_rd_ptr];
  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid & scan_ready;
  assign w_room  = (32'(r_count) + 32'(w_inflight)) < FIFO_DEPTH;

  // Scan FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Scan FSM next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_load) w_next = S_RUN;
      S_RUN: begin
        if (scan_abort)                               w_next = S_IDLE;
        else if (w_issue && r_remain == LEN_WIDTH'(1)) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (scan_abort)                w_next = S_IDLE;
        else if (w_pop && w_head.eop)  w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Scan FSM outputs: load, issue and flush strobes
  always_comb begin
    w_load  = 1'b0;
    w_issue = 1'b0;
    w_flush = 1'b0;
    case (r_state)
      S_IDLE:  w_load = scan_start & (scan_words != '0) & ~scan_abort;
      S_RUN: begin
        w_flush = scan_abort;
        w_issue = ~scan_abort & w_room;
      end
      S_DRAIN: w_flush = scan_abort;
      default: ;
    endcase
  end

  // Scan address/length counters; address wraps at DEPTH
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr   <= '0;
      r_remain <= '0;
      r_first  <= 1'b0;
    end else if (w_load) begin
      r_addr   <= scan_base;
      r_remain <= scan_words;
      r_first  <= 1'b1;
    end else if (w_issue) begin
      r_addr   <= (r_addr >= LAST_ADDR) ? '0 : r_addr + ADDR_WIDTH'(1);
      r_remain <= r_remain - LEN_WIDTH'(1);
      r_first  <= 1'b0;
    end
  end

`ifdef ONCHIP_RAM_OUTREG_EN
  scan_entry_t r_pipe;
  logic        r_pipe_v;

  // Extra read stage between RAM port B and the skid FIFO
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pipe   <= '0;
      r_pipe_v <= 1'b0;
    end else begin
      r_pipe_v <= w_issue & ~w_flush;
      if (w_issue) r_pipe <= w_rd_entry;
    end
  end

  assign w_inflight   = r_pipe_v;
  assign w_push       = r_pipe_v & ~w_flush;
  assign w_push_entry = r_pipe;
`else
  assign w_inflight   = 1'b0;
  assign w_push       = w_issue;
  assign w_push_entry = w_rd_entry;
`endif

  // Skid FIFO: absorbs words in flight while the sink stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fifo   <= '{default: '0};
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_push_entry;
        r_wr_ptr         <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_pop)
        r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  assign scan_valid = w_valid;
  assign scan_data  = w_head.data;
  assign scan_sop   = w_valid & w_head.sop;
  assign scan_eop   = w_valid & w_head.eop;
  assign scan_busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_vga_onchip_ram_scan.sv
// Testbench for vga_onchip_ram_scan: directed test-plan cases plus randomized
// s1 traffic and scans, checked against an array model of the RAM.
module tb_vga_onchip_ram_scan;

  localparam int DEPTH = 33000;
`ifdef ONCHIP_RAM_OUTREG_EN
  localparam int S1_LAT   = 2;
  localparam int SCAN_LAT = 3;
`else
  localparam int S1_LAT   = 1;
  localparam int SCAN_LAT = 2;
`endif

  logic        clk;
  logic        reset;
  logic        clken;
  logic        reset_req;
  logic [15:0] s1_address;
  logic [3:0]  s1_byteenable;
  logic        s1_chipselect;
  logic        s1_read;
  logic        s1_write;
  logic [31:0] s1_writedata;
  logic [31:0] s1_readdata;
  logic        s1_readdatavalid;
  logic        s1_waitrequest;
  logic        scan_start;
  logic        scan_abort;
  logic [15:0] scan_base;
  logic [15:0] scan_words;
  logic [31:0] scan_data;
  logic        scan_valid;
  logic        scan_ready;
  logic        scan_sop;
  logic        scan_eop;
  logic        scan_busy;

  logic [31:0] model [DEPTH];
  int n_checks = 0;
  int n_errors = 0;

  vga_onchip_ram_scan dut (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
    .s1_address(s1_address), .s1_byteenable(s1_byteenable),
    .s1_chipselect(s1_chipselect), .s1_read(s1_read), .s1_write(s1_write),
    .s1_writedata(s1_writedata), .s1_readdata(s1_readdata),
    .s1_readdatavalid(s1_readdatavalid), .s1_waitrequest(s1_waitrequest),
    .scan_start(scan_start), .scan_abort(scan_abort), .scan_base(scan_base),
    .scan_words(scan_words), .scan_data(scan_data), .scan_valid(scan_valid),
    .scan_ready(scan_ready), .scan_sop(scan_sop), .scan_eop(scan_eop),
    .scan_busy(scan_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge
  task automatic s1_wr(input int addr, input logic [31:0] data, input logic [3:0] be);
    s1_address = 16'(addr); s1_writedata = data; s1_byteenable = be;
    s1_chipselect = 1'b1; s1_write = 1'b1;
    @(posedge clk); #1;
    s1_chipselect = 1'b0; s1_write = 1'b0;
    if (addr < DEPTH)
      for (int i = 0; i < 4; i++)
        if (be[i]) model[addr][8*i +: 8] = data[8*i +: 8];
  endtask

  task automatic s1_rd(input int addr, input string tag, output logic [31:0] got);
    logic [31:0] exp;
    exp = (addr < DEPTH) ? model[addr] : 32'h0;
    s1_address = 16'(addr); s1_chipselect = 1'b1; s1_read = 1'b1;
    @(posedge clk); #1;
    s1_chipselect = 1'b0; s1_read = 1'b0;
    for (int i = 1; i < S1_LAT; i++) begin
      check({tag, "_rdv_early"}, s1_readdatavalid, 1'b0);
      @(posedge clk); #1;
    end
    check({tag, "_rdv"}, s1_readdatavalid, 1'b1);
    check({tag, "_data"}, s1_readdata, exp);
    got = s1_readdata;
    @(posedge clk); #1;
    check({tag, "_rdv_pulse"}, s1_readdatavalid, 1'b0);
    check({tag, "_hold"}, s1_readdata, exp);
  endtask

  task automatic preload(input int base, input int n);
    for (int i = 0; i < n; i++) s1_wr((base + i) % DEPTH, $urandom, 4'hF);
  endtask

  // mode: 0 ready=1, 1 ready pattern 1,0,0,1, 2 random ready
  // opt:  1 pulse a second scan_start mid-scan, 2 s1 write collides with first read
  task automatic run_scan(input int base, input int words, input int mode, input int opt);
    logic [31:0] exp_q [$];
    logic [31:0] prev_data, coll;
    logic        prev_sop, prev_eop, prev_stall;
    int          idx, cyc;
    bit          done;
    for (int i = 0; i < words; i++) exp_q.push_back(model[(base + i) % DEPTH]);
    coll = ~model[base];
    scan_base = 16'(base); scan_words = 16'(words); scan_start = 1'b1; scan_ready = 1'b1;
    @(posedge clk); #1;
    scan_start = 1'b0;
    idx = 0; cyc = 0; done = 0; prev_stall = 0;
    prev_data = '0; prev_sop = 0; prev_eop = 0;
    while (!done && cyc < 400) begin
      case (mode)
        0:       scan_ready = 1'b1;
        1:       scan_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: scan_ready = 1'($urandom_range(0, 1));
      endcase
      if (opt == 1 && cyc == 3) begin
        scan_start = 1'b1; scan_base = 16'((base + 5) % DEPTH); scan_words = 16'd3;
      end
      if (opt == 1 && cyc == 4) scan_start = 1'b0;
      if (opt == 2 && cyc == 0) begin
        s1_address = 16'(base); s1_writedata = coll; s1_byteenable = 4'hF;
        s1_chipselect = 1'b1; s1_write = 1'b1;
      end
      if (opt == 2 && cyc == 1) begin
        s1_chipselect = 1'b0; s1_write = 1'b0; model[base] = coll;
      end
      @(negedge clk);
      if (cyc == SCAN_LAT - 2) check("scan_lat_early", scan_valid, 1'b0);
      if (cyc == SCAN_LAT - 1) check("scan_lat_first", scan_valid, 1'b1);
      if (prev_stall) begin
        check("hold_valid", scan_valid, 1'b1);
        check("hold_data", scan_data, prev_data);
        check("hold_sopeop", {scan_sop, scan_eop}, {prev_sop, prev_eop});
      end
      if (scan_valid && scan_ready) begin
        if (idx < words) begin
          check("scan_data", scan_data, exp_q[idx]);
          check("scan_sop", scan_sop, idx == 0);
          check("scan_eop", scan_eop, idx == words - 1);
        end
        if (scan_eop) done = 1;
        idx++;
      end
      prev_stall = scan_valid && !scan_ready;
      prev_data = scan_data; prev_sop = scan_sop; prev_eop = scan_eop;
      @(posedge clk); #1;
      cyc++;
    end
    check("scan_count", idx, words);
    check("scan_busy_end", scan_busy, 1'b0);
    check("scan_valid_end", scan_valid, 1'b0);
  endtask

  initial begin
    logic [31:0] got;
    int          acc, cyc;

    reset = 1'b1; clken = 1'b1; reset_req = 1'b0;
    s1_address = '0; s1_byteenable = '0; s1_chipselect = 1'b0;
    s1_read = 1'b0; s1_write = 1'b0; s1_writedata = '0;
    scan_start = 1'b0; scan_abort = 1'b0; scan_base = '0; scan_words = '0; scan_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata", s1_readdata, 32'h0);
    check("rst_rdv", s1_readdatavalid, 1'b0);
    check("rst_wait", s1_waitrequest, 1'b1);
    check("rst_scan", {scan_valid, scan_sop, scan_eop, scan_busy}, 4'b0);
    check("rst_sdata", scan_data, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("wait_idle", s1_waitrequest, 1'b0);

    // Byte-lane merge
    s1_wr(5, 32'hAABBCCDD, 4'hF);
    s1_wr(5, 32'h11223344, 4'h5);
    s1_rd(5, "tp1", got);
    check("tp1_merge", got, 32'hAA22CC44);

    // Stall via clken and reset_req; out-of-range access
    s1_wr(7, 32'h12345678, 4'hF);
    clken = 1'b0;
    s1_address = 16'd7; s1_writedata = 32'hDEADBEEF; s1_byteenable = 4'hF;
    s1_chipselect = 1'b1; s1_write = 1'b1;
    #1 check("stall_wait_clken", s1_waitrequest, 1'b1);
    @(posedge clk); #1;
    s1_write = 1'b0; s1_read = 1'b1;
    @(posedge clk); #1;
    check("stall_no_rdv", s1_readdatavalid, 1'b0);
    s1_read = 1'b0; s1_chipselect = 1'b0; clken = 1'b1; reset_req = 1'b1;
    s1_chipselect = 1'b1; s1_write = 1'b1;
    #1 check("stall_wait_rreq", s1_waitrequest, 1'b1);
    @(posedge clk); #1;
    s1_chipselect = 1'b0; s1_write = 1'b0; reset_req = 1'b0;
    s1_rd(7, "stall_kept", got);
    s1_wr(DEPTH, 32'h55AA55AA, 4'hF);
    s1_rd(DEPTH, "oor", got);

    // Read and write together: write wins, no readdatavalid
    s1_address = 16'd10; s1_writedata = 32'hCAFEF00D; s1_byteenable = 4'hF;
    s1_chipselect = 1'b1; s1_read = 1'b1; s1_write = 1'b1;
    @(posedge clk); #1;
    s1_chipselect = 1'b0; s1_read = 1'b0; s1_write = 1'b0;
    model[10] = 32'hCAFEF00D;
    repeat (S1_LAT) begin
      check("rw_no_rdv", s1_readdatavalid, 1'b0);
      @(posedge clk); #1;
    end
    s1_rd(10, "rw_data", got);

    // Full-rate and backpressured scans of words 0..7
    for (int i = 0; i < 8; i++) s1_wr(i, 32'(i), 4'hF);
    run_scan(0, 8, 0, 0);
    run_scan(0, 8, 1, 0);

    // Wrap, single word, zero length
    preload(DEPTH - 2, 4);
    run_scan(DEPTH - 2, 4, 0, 0);
    preload(50, 1);
    run_scan(50, 1, 1, 0);
    scan_base = 16'd0; scan_words = 16'd0; scan_start = 1'b1;
    @(posedge clk); #1;
    scan_start = 1'b0;
    check("zero_len_busy", scan_busy, 1'b0);
    @(posedge clk); #1;
    check("zero_len_valid", scan_valid, 1'b0);

    // Collision: scan reads old data; start while busy is ignored
    preload(200, 4);
    run_scan(200, 4, 0, 2);
    s1_rd(200, "coll_new", got);
    preload(600, 16);
    run_scan(600, 16, 2, 1);

    // Abort after 3 words, then a normal scan
    preload(300, 16);
    scan_base = 16'd300; scan_words = 16'd16; scan_ready = 1'b1; scan_start = 1'b1;
    @(posedge clk); #1;
    scan_start = 1'b0;
    acc = 0; cyc = 0;
    while (acc < 3 && cyc < 50) begin
      @(negedge clk);
      if (scan_valid && scan_ready) begin
        check("abort_pre_data", scan_data, model[300 + acc]);
        acc++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check("abort_pre_count", acc, 3);
    scan_abort = 1'b1;
    @(posedge clk); #1;
    scan_abort = 1'b0;
    check("abort_valid", scan_valid, 1'b0);
    check("abort_busy", scan_busy, 1'b0);
    @(posedge clk); #1;
    check("abort_stays_idle", {scan_valid, scan_busy}, 2'b00);
    run_scan(300, 16, 0, 0);

    // Abort together with start in IDLE: start ignored
    scan_base = 16'd300; scan_words = 16'd4; scan_start = 1'b1; scan_abort = 1'b1;
    @(posedge clk); #1;
    scan_start = 1'b0; scan_abort = 1'b0;
    check("abort_start_busy", scan_busy, 1'b0);
    repeat (SCAN_LAT) @(posedge clk);
    #1 check("abort_start_valid", scan_valid, 1'b0);

    // Reset mid-scan: outputs cleared, memory intact
    preload(400, 20);
    scan_base = 16'd400; scan_words = 16'd20; scan_ready = 1'b0; scan_start = 1'b1;
    @(posedge clk); #1;
    scan_start = 1'b0;
    s1_address = 16'd400; s1_chipselect = 1'b1; s1_read = 1'b1;
    @(posedge clk); #1;
    s1_chipselect = 1'b0; s1_read = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mrst_scan", {scan_valid, scan_sop, scan_eop, scan_busy}, 4'b0);
    check("mrst_sdata", scan_data, 32'h0);
    check("mrst_s1", {s1_readdatavalid, s1_readdata}, 33'h0);
    s1_rd(400, "mrst_mem", got);
    run_scan(400, 20, 2, 0);

    // Randomized s1 traffic over a preloaded window
    preload(0, 16);
    for (int t = 0; t < 24; t++) begin
      int a;
      a = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) s1_wr(a, $urandom, 4'($urandom_range(0, 15)));
      else                           s1_rd(a, "rand_s1", got);
    end

    // Randomized scans, some wrapping
    for (int t = 0; t < 6; t++) begin
      int b, w;
      b = (t % 2 == 1) ? DEPTH - 1 - $urandom_range(0, 5) : $urandom_range(0, DEPTH - 1);
      w = $urandom_range(1, 20);
      preload(b, w);
      s1_wr((b + w / 2) % DEPTH, $urandom, 4'($urandom_range(0, 15)));
      run_scan(b, w, 2, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_onchip_ram_scan.md
Name: vga_onchip_ram_scan

Overview:
Parametrised successor to the single-port Nios on-chip RAM. True dual-port memory with:
- a Nios-facing Avalon-MM slave (s1) with pipelined reads, readdatavalid and waitrequest;
- an autonomous scan-out read port that streams a contiguous word range to the VGA pixel path over a valid/ready handshake with backpressure.

It sits between the Nios data master and the VGA pixel formatter as a framebuffer.

Parameters:
- DATA_WIDTH, 32: word width in bits; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8: bits per byteenable lane.
- ADDR_WIDTH, 16: word-address width of both ports.
- DEPTH, 33000: number of words; must be at most 2^ADDR_WIDTH.
- LEN_WIDTH, 16: width of the scan length port.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- clken  in  1  s1 clock enable; 0 stalls s1.
- reset_req  in  1  reset request; 1 stalls s1, same as clken=0.
- s1_address  in  ADDR_WIDTH  word address.
- s1_byteenable  in  DATA_WIDTH/BYTE_WIDTH  write lane enables.
- s1_chipselect  in  1  slave select.
- s1_read  in  1  read request.
- s1_write  in  1  write request.
- s1_writedata  in  DATA_WIDTH  write data.
- s1_readdata  out  DATA_WIDTH  read data.
- s1_readdatavalid  out  1  read data valid.
- s1_waitrequest  out  1  slave busy.
- scan_start  in  1  one-cycle start pulse.
- scan_abort  in  1  cancel an active scan.
- scan_base  in  ADDR_WIDTH  first word of the scan.
- scan_words  in  LEN_WIDTH  number of words to stream.
- scan_data  out  DATA_WIDTH  streamed word.
- scan_valid  out  1  scan_data is valid.
- scan_ready  in  1  sink accepts the word.
- scan_sop  out  1  first word of the scan.
- scan_eop  out  1  last word of the scan.
- scan_busy  out  1  state is not IDLE.

Behaviour:
- Clock and reset: clk and reset, synchronous active-high.
- Reset values: s1_readdata=0, s1_readdatavalid=0, scan_data=0, scan_valid/sop/eop=0, scan_busy=0, state=IDLE, skid buffer empty.
- s1_waitrequest:
  - combinational: ~clken | reset_req | reset.
  - A transfer is accepted only when chipselect=1 and waitrequest=0.
- s1 write: merges enabled byte lanes only. If s1_address >= DEPTH the write is dropped.
- s1 read:
  - s1_readdatavalid is a 1-cycle pulse exactly 1 cycle after acceptance.
  - s1_address >= DEPTH returns 0.
  - s1_readdata holds its last value when valid is low.
- s1_read and s1_write together: the write wins; no readdatavalid is produced.
- Scan port is read-only, on RAM port B.
- Same-address collision: a scan read and an s1 write to the same address in the same cycle return the OLD data.
- Scan FSM:
  - IDLE: scan_start with scan_words != 0 latches base and length, then moves to RUN. scan_start with scan_words == 0 is ignored.
  - RUN: issue one RAM read per cycle while (skid occupancy + reads in flight) < 2. Address increments by 1 per issue. When the last address is issued, move to DRAIN.
  - DRAIN: when the eop word is accepted (scan_valid & scan_ready & scan_eop), move to IDLE.
- Address wrap: an address that reaches DEPTH wraps to 0, not to 2^ADDR_WIDTH.
- Output buffer: 2-entry skid FIFO, so there is no bubble at full throughput.
- Throughput and latency:
  - scan_ready held at 1 gives 1 word/cycle.
  - First scan_valid appears 2 cycles after scan_start.
- Stream stability: scan_data, scan_sop and scan_eop are stable while scan_valid=1 and scan_ready=0.
- scan_sop is set on the first word only; scan_eop on word scan_words-1 only. scan_words=1 asserts both on the same word.
- Start and abort:
  - scan_start while scan_busy=1 is ignored.
  - scan_abort in RUN or DRAIN: next cycle state=IDLE, FIFO flushed, scan_valid=0, and in-flight reads are discarded.
  - scan_abort in IDLE: no effect.
  - scan_abort together with scan_start: abort wins; the FIFO is flushed and the start is ignored.
- Reset mid-scan: everything returns to reset values in the next cycle. RAM contents are preserved (no clear).
- Independence: s1 and the scan port are fully independent; neither stalls the other.

Optional Feature:
ONCHIP_RAM_OUTREG_EN
- Defined: s1 read data passes through an extra output register, so readdatavalid pulses 2 cycles after acceptance. The output register is frozen while clken=0. The scan path gets a 3-entry skid FIFO and first scan_valid appears 3 cycles after start.
- Undefined: behaviour as above, with s1 latency 1 and scan latency 2.

Test Plan:
1. Byte-lane write: s1 writes 0xAABBCCDD to address 5 with byteenable 0xF, then 0x11223344 with byteenable 0x5. Reading address 5 returns 0xAA22CC44, with readdatavalid 1 cycle after acceptance.
2. Stall and out-of-range: with clken=0, s1_waitrequest=1 and nothing is accepted. A write to address 33000 is dropped; a read of address 33000 returns 0.
3. Full-rate scan: preload words 0..7 with the value i. scan_base=0, scan_words=8, scan_ready=1 gives 8 consecutive valid words 0..7, sop on word 0, eop on word 7. scan_busy drops the cycle after eop is accepted.
4. Backpressure: the same 8-word scan with scan_ready toggling 1,0,0,1. No word is lost or duplicated, and data is held while ready=0.
5. Wrap and length-1: scan_base=32998, scan_words=4 streams addresses 32998, 32999, 0, 1. scan_words=1 gives a single word with sop=eop=1. scan_words=0 leaves scan_busy=0.
6. Abort and reset: scan_abort after 3 words gives scan_valid=0 and scan_busy=0 the next cycle, and a new scan_start runs normally. reset mid-scan clears outputs while memory contents stay intact.
